// File: rtl/ps2_pkg.sv
// ps2_pkg: shared states, command bytes and default timing for the PS/2 host path
package ps2_pkg;
  typedef enum logic [3:0] {IDLE, INHIBIT, REQ, WAIT_CLK, SEND, ACK, WAIT_IDLE, DONE, FAIL} state_t;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO = 8'hEE;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam int INHIBIT_CYCLES_DEF = 10000;
  localparam int START_TIMEOUT_DEF = 1500000;
  localparam int XFER_TIMEOUT_DEF = 200000;
  localparam int FILTER_LEN_DEF = 8;
  localparam int TIMER_W = 21;
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_tx_filter.sv
// ps2_line_filter: 2-FF synchroniser plus stability filter with falling-edge strobe
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall_stb
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      fall_stb <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      fall_stb <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= s2;
        cnt <= '0;
        fall_stb <= level;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter over open-drain clock/data
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int XFER_TIMEOUT = XFER_TIMEOUT_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  state_t state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] byte_q, byte_n;
  logic par, par_n, drv, drv_n, ack, ack_n;
  logic clk_f, data_f, fall_stb, data_fall_unused, xto;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
    .clk(clk_100mhz), .rst(rst), .pin(ps2_clk_in), .level(clk_f), .fall_stb(fall_stb)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data (
    .clk(clk_100mhz), .rst(rst), .pin(ps2_data_in), .level(data_f), .fall_stb(data_fall_unused)
  );
  assign xto = timer == TIMER_W'(XFER_TIMEOUT - 1);
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      bit_cnt <= '0;
      byte_q <= '0;
      par <= 1'b0;
      drv <= 1'b0;
      ack <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      bit_cnt <= bit_cnt_n;
      byte_q <= byte_n;
      par <= par_n;
      drv <= drv_n;
      ack <= ack_n;
    end
  end
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    bit_cnt_n = bit_cnt;
    byte_n = byte_q;
    par_n = par;
    drv_n = drv;
    ack_n = ack;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        bit_cnt_n = '0;
        if (tx_start) begin
          byte_n = tx_data;
          par_n = odd_par(tx_data);
          state_n = INHIBIT;
        end
      end
      INHIBIT: state_n = (timer == TIMER_W'(INHIBIT_CYCLES - 1)) ? REQ : INHIBIT;
      REQ: begin
        timer_n = '0;
        state_n = WAIT_CLK;
      end
      WAIT_CLK: begin
        if (timer == TIMER_W'(START_TIMEOUT - 1)) state_n = FAIL;
        else if (fall_stb) begin
          drv_n = ~byte_q[0];
          bit_cnt_n = 4'd1;
          timer_n = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (xto) state_n = FAIL;
        else if (fall_stb) begin
          bit_cnt_n = bit_cnt + 1'b1;
          drv_n = (bit_cnt >= 4'd9) ? 1'b0 : (bit_cnt == 4'd8) ? ~par : ~byte_q[bit_cnt[2:0]];
          if (bit_cnt == 4'd10) begin
            ack_n = data_f;
            state_n = ACK;
          end
        end
      end
      ACK: state_n = (xto || ack) ? FAIL : WAIT_IDLE;
      WAIT_IDLE: state_n = xto ? FAIL : (clk_f && data_f) ? DONE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
  assign ps2_data_oe = (state == REQ) || (state == WAIT_CLK) || ((state == SEND) && drv);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign error = state == FAIL;
endmodule
